// File: rtl/multicycle_borrow_subtractor_pkg.sv
// Shared definitions for the multicycle borrow subtractor: FSM state
// encoding and the slice-counter width helper.
package multicycle_borrow_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice counter width: clog2(number of slices), never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multicycle_borrow_subtractor_chunk.sv
// One CHUNK-bit borrow-lookahead subtraction slice, purely combinational.
// Bit generate g = ~x & y (a borrow starts here), bit propagate
// p = ~(x ^ y) (an incoming borrow passes through). Each internal borrow is
// formed from the prefix group terms and the slice borrow-in, so no bit
// waits on a ripple from its neighbour.
module chunk_borrow_lookahead_subtractor #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_x,
  input  logic [CHUNK-1:0] i_y,
  input  logic             i_borrow_in,
  output logic [CHUNK-1:0] o_z,
  output logic             o_borrow_out,
  output logic             o_group_generate,
  output logic             o_group_propagate
);

  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_pg;   // group generate over bits [i:0]
  logic [CHUNK-1:0] w_pp;   // group propagate over bits [i:0]
  logic [CHUNK-1:0] w_b;    // borrow into bit i

  assign w_g = ~i_x & i_y;
  assign w_p = ~(i_x ^ i_y);

  // Prefix group terms, then every bit borrow straight from them and borrow_in.
  always_comb begin
    w_pg    = '0;
    w_pp    = '0;
    w_b     = '0;
    w_pg[0] = w_g[0];
    w_pp[0] = w_p[0];
    for (int i = 1; i < CHUNK; i++) begin
      w_pg[i] = w_g[i] | (w_p[i] & w_pg[i-1]);
      w_pp[i] = w_p[i] & w_pp[i-1];
    end
    w_b[0] = i_borrow_in;
    for (int i = 1; i < CHUNK; i++) begin
      w_b[i] = w_pg[i-1] | (w_pp[i-1] & i_borrow_in);
    end
  end

  assign o_z               = i_x ^ i_y ^ w_b;
  assign o_group_generate  = w_pg[CHUNK-1];
  assign o_group_propagate = w_pp[CHUNK-1];
  assign o_borrow_out      = w_pg[CHUNK-1] | (w_pp[CHUNK-1] & i_borrow_in);

endmodule

// File: rtl/multicycle_borrow_subtractor.sv
// Multicycle subtractor: z = x - y - borrow_in, one CHUNK-bit slice per
// clock, LSB slice first. A single lookahead slice is reused every cycle;
// the inter-slice borrow lives in r_borrow. WIDTH must be a multiple of
// CHUNK. Operands in and results out use valid/ready handshakes.
module multicycle_borrow_subtractor
  import multicycle_borrow_subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_borrow_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_z,
  output logic             o_borrow_out,
  output logic             o_overflow,
  output logic             o_zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);

  state_e             r_state;
  state_e             w_state_next;
  logic               w_accept;
  logic               w_calc;
  logic               w_in_ready;
  logic               w_out_valid;

  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_z;
  logic [CW-1:0]      r_cnt;
  logic               r_borrow;
  logic               r_borrow_out;
  logic               r_overflow;
  logic               r_zero;

  logic [CHUNK-1:0]   w_xs;
  logic [CHUNK-1:0]   w_ys;
  logic [CHUNK-1:0]   w_zs;
  logic               w_slice_bout;
  logic               w_gg;
  logic               w_gp;
  logic               w_last;
  logic [WIDTH-1:0]   w_z_next;
  logic               w_unused;

  assign w_last = (r_cnt == CW'(N - 1));

  // State register; reset forces IDLE and discards any in-flight result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state, handshake strobes and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_calc       = 1'b0;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        w_calc = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (i_out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;

  // Slice select: pick operand slice r_cnt and splice its result into z.
  always_comb begin
    w_xs     = '0;
    w_ys     = '0;
    w_z_next = r_z;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CW'(k)) begin
        w_xs                        = r_x[k*CHUNK +: CHUNK];
        w_ys                        = r_y[k*CHUNK +: CHUNK];
        w_z_next[k*CHUNK +: CHUNK]  = w_zs;
      end
    end
  end

  chunk_borrow_lookahead_subtractor #(
    .CHUNK (CHUNK)
  ) u_slice (
    .i_x               (w_xs),
    .i_y               (w_ys),
    .i_borrow_in       (r_borrow),
    .o_z               (w_zs),
    .o_borrow_out      (w_slice_bout),
    .o_group_generate  (w_gg),
    .o_group_propagate (w_gp)
  );

  // Group terms only matter when slices are chained combinationally; one
  // slice per cycle only needs the slice borrow-out.
  assign w_unused = &{1'b0, w_gg, w_gp};

  // Operand capture, per-slice result write and final flag registration.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_cnt        <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else if (w_accept) begin
      r_x      <= i_x;
      r_y      <= i_y;
      r_borrow <= i_borrow_in;
      r_cnt    <= '0;
    end else if (w_calc) begin
      r_z      <= w_z_next;
      r_borrow <= w_slice_bout;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_borrow_out <= w_slice_bout;
        r_overflow   <= (r_x[WIDTH-1] != r_y[WIDTH-1]) &&
                        (w_z_next[WIDTH-1] != r_x[WIDTH-1]);
        r_zero       <= (w_z_next == '0);
      end
    end
  end

  assign o_z          = r_z;
  assign o_borrow_out = r_borrow_out;
  assign o_overflow   = r_overflow;
  assign o_zero       = r_zero;

endmodule
